// File: rtl/nubus_burst_master.sv
// nubus_burst_master: NuBus master transfer engine with block transfers,
// a write-data buffer, read-data streaming, slave status decode and
// automatic retry on try-again-later.
// Optional local data-phase timeout: define NUBUS_BURST_TIMEOUT_EN.
module nubus_burst_master #(
  parameter int BLOCK_MAX      = 8,
  parameter int RETRY_MAX      = 4,
  parameter int RETRY_GAP      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        nub_clk,
  input  logic        nub_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [4:0]  req_len,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        done,
  output logic [1:0]  status,
  input  logic        arb_grant,
  input  logic        bus_busy,
  output logic        arbcy,
  output logic        rqst,
  output logic        start,
  output logic [1:0]  tm_o,
  output logic        tm_oe,
  output logic [31:0] ad_o,
  output logic        ad_oe,
  input  logic [31:0] ad_i,
  input  logic        ack_i,
  input  logic [1:0]  tm_i
);

  localparam int         BW           = $clog2(BLOCK_MAX);
  localparam logic [7:0] LP_RETRY_MAX = 8'(RETRY_MAX);
  localparam logic [7:0] LP_GAP_LAST  = (RETRY_GAP > 0) ? 8'(RETRY_GAP - 1) : 8'd0;
`ifdef NUBUS_BURST_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT  = 16'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARB, S_ADDR, S_DATA, S_CHECK, S_GAP, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic        r_write;
  logic [4:0]  r_len;
  logic [4:0]  r_wptr;
  logic [4:0]  r_beat;
  logic [1:0]  r_tm;
  logic [7:0]  r_retry;
  logic [7:0]  r_gap;
`ifdef NUBUS_BURST_TIMEOUT_EN
  logic [15:0] r_to_cnt;
`endif
  logic [31:0] r_buf [BLOCK_MAX];

  logic        r_req_ready, r_rdata_valid, r_done, r_arbcy, r_rqst, r_start;
  logic        r_tm_oe, r_ad_oe;
  logic [31:0] r_rdata, r_ad_o;
  logic [1:0]  r_status, r_tm_o;

  logic [3:0]  w_blk_code;
  logic [31:0] w_addr_phase;
  logic [4:0]  w_beat_inc;
  logic        w_buf_we;
  logic [31:0] w_buf_nxt;

  // Block size code for the address cycle: log2 of the beat count
  always_comb begin
    w_blk_code = 4'd0;
    case (r_len)
      5'd1:    w_blk_code = 4'd1;
      5'd3:    w_blk_code = 4'd2;
      5'd7:    w_blk_code = 4'd3;
      5'd15:   w_blk_code = 4'd4;
      default: w_blk_code = 4'd0;
    endcase
  end

  assign w_addr_phase = (r_len == 5'd0) ? r_addr : {r_addr[31:6], w_blk_code, 2'b00};
  assign w_beat_inc   = r_beat + 5'd1;
  assign w_buf_we     = (r_state == S_LOAD) && wdata_valid;
  assign w_buf_nxt    = r_buf[w_beat_inc[BW-1:0]];

  // Write-data buffer; only filled in LOAD, contents survive retries
  always_ff @(posedge nub_clk) begin
    if (w_buf_we) r_buf[r_wptr[BW-1:0]] <= wdata;
  end

  // Transfer FSM with registered bus and CPU-side outputs
  always_ff @(posedge nub_clk or posedge nub_reset) begin
    if (nub_reset) begin
      r_state <= S_IDLE;
      r_addr <= '0; r_write <= 1'b0; r_len <= '0; r_wptr <= '0; r_beat <= '0;
      r_tm <= '0; r_retry <= '0; r_gap <= '0;
`ifdef NUBUS_BURST_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
      r_req_ready <= 1'b1; r_rdata_valid <= 1'b0; r_rdata <= '0; r_done <= 1'b0;
      r_status <= '0; r_arbcy <= 1'b0; r_rqst <= 1'b0; r_start <= 1'b0;
      r_tm_o <= '0; r_tm_oe <= 1'b0; r_ad_o <= '0; r_ad_oe <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_addr      <= req_addr;
            r_write     <= req_write;
            r_len       <= req_len;
            r_wptr      <= '0;
            r_retry     <= '0;
            r_req_ready <= 1'b0;
            if (req_write) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_ARB;
              r_rqst  <= 1'b1;
              r_arbcy <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (wdata_valid) begin
            if (r_wptr == r_len) begin
              r_state <= S_ARB;
              r_rqst  <= 1'b1;
              r_arbcy <= 1'b1;
            end else begin
              r_wptr <= r_wptr + 5'd1;
            end
          end
        end
        S_ARB: begin
          if (arb_grant && !bus_busy) begin
            r_state <= S_ADDR;
            r_rqst  <= 1'b0;
            r_arbcy <= 1'b0;
            r_start <= 1'b1;
            r_ad_oe <= 1'b1;
            r_ad_o  <= w_addr_phase;
            r_tm_oe <= 1'b1;
            r_tm_o  <= {~r_write, 1'b1};
          end
        end
        S_ADDR: begin
          r_start <= 1'b0;
          r_tm_oe <= 1'b0;
          r_tm_o  <= '0;
          r_beat  <= '0;
`ifdef NUBUS_BURST_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          // An ack already in the address cycle closes a single-beat transfer
          if (ack_i) begin
            r_tm    <= tm_i;
            r_state <= S_CHECK;
            r_ad_oe <= 1'b0;
            r_ad_o  <= '0;
            if (!r_write) begin
              r_rdata       <= ad_i;
              r_rdata_valid <= 1'b1;
            end
          end else begin
            r_state <= S_DATA;
            r_ad_oe <= r_write;
            r_ad_o  <= r_write ? r_buf[0] : '0;
          end
        end
        S_DATA: begin
          if (ack_i) begin
            r_tm    <= tm_i;
            r_state <= S_CHECK;
            r_ad_oe <= 1'b0;
            r_ad_o  <= '0;
            if (!r_write) begin
              r_rdata       <= ad_i;
              r_rdata_valid <= 1'b1;
            end
          end else if (tm_i[0]) begin
`ifdef NUBUS_BURST_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            // Beats beyond len are dropped so the index never overruns
            if (r_beat != r_len) begin
              r_beat <= w_beat_inc;
              if (r_write) begin
                r_ad_o <= w_buf_nxt;
              end else begin
                r_rdata       <= ad_i;
                r_rdata_valid <= 1'b1;
              end
            end
          end else begin
`ifdef NUBUS_BURST_TIMEOUT_EN
            if (r_to_cnt + 16'd1 >= LP_TIMEOUT) begin
              r_ad_oe  <= 1'b0;
              r_ad_o   <= '0;
              r_done   <= 1'b1;
              r_status <= 2'd2;
              r_state  <= S_DONE;
            end else begin
              r_to_cnt <= r_to_cnt + 16'd1;
            end
`endif
          end
        end
        S_CHECK: begin
          case (r_tm)
            2'b00: begin
              r_done <= 1'b1; r_status <= 2'd0; r_state <= S_DONE;
            end
            2'b11: begin
              if (r_retry < LP_RETRY_MAX) begin
                r_state <= S_GAP;
                r_gap   <= '0;
              end else begin
                r_done <= 1'b1; r_status <= 2'd3; r_state <= S_DONE;
              end
            end
            default: begin
              r_done <= 1'b1; r_status <= 2'd1; r_state <= S_DONE;
            end
          endcase
        end
        S_GAP: begin
          if (r_gap >= LP_GAP_LAST) begin
            r_state <= S_ARB;
            r_rqst  <= 1'b1;
            r_arbcy <= 1'b1;
            r_retry <= r_retry + 8'd1;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_retry     <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign done        = r_done;
  assign status      = r_status;
  assign arbcy       = r_arbcy;
  assign rqst        = r_rqst;
  assign start       = r_start;
  assign tm_o        = r_tm_o;
  assign tm_oe       = r_tm_oe;
  assign ad_o        = r_ad_o;
  assign ad_oe       = r_ad_oe;

endmodule

// File: doc/nubus_burst_master.md
Name: nubus_burst_master

Overview:
- Parametrised NuBus master transfer engine; the next generation of the card's master path.
- Adds block transfers (1..BLOCK_MAX words), a write-data buffer, and read-data streaming.
- Decodes slave status: complete, error, timeout, try-again-later. Try-again-later triggers automatic re-arbitration and retry.
- Sits between the CPU request port and the NuBus pad drivers/arbiter. All NuBus-side signals are active-high and split into in/out/oe; pad inversion is done in the top level.

Parameters:
- BLOCK_MAX, 8, maximum words per block transfer; power of two, 2..16.
- RETRY_MAX, 4, try-again-later retries before reporting error; 0 = no retry.
- RETRY_GAP, 3, idle cycles between a try-again-later and the next bus request.
- TIMEOUT_CYCLES, 255, data-phase cycles without slave response before a local timeout.

Ports:
- nub_clk  in  1  NuBus clock; rising edge drives, all state updates on the rising edge.
- nub_reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  engine idle and able to accept a request.
- req_addr  in  32  word address; bits [1:0] ignored.
- req_write  in  1  1 = write, 0 = read.
- req_len  in  5  beat count minus 1; must be 0 or 2^k-1, and < BLOCK_MAX.
- wdata_valid  in  1  write word push.
- wdata  in  32  write word.
- rdata_valid  out  1  one-cycle strobe, read word available.
- rdata  out  32  read word.
- done  out  1  one-cycle strobe at end of request.
- status  out  2  final status, valid with done: 0 ok, 1 error, 2 timeout, 3 retries exhausted.
- arb_grant  in  1  arbiter grant.
- bus_busy  in  1  START or ACK currently active on bus.
- arbcy  out  1  enable arbiter contest.
- rqst  out  1  NuBus RQST.
- start  out  1  NuBus START.
- tm_o  out  2  TM driven during address cycle.
- tm_oe  out  1  TM output enable.
- ad_o  out  32  AD output.
- ad_oe  out  1  AD output enable.
- ad_i  in  32  AD sampled.
- ack_i  in  1  slave ACK, final beat.
- tm_i  in  2  slave status / intermediate-beat flag (tm_i[0] with ack_i=0 = intermediate beat).

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM=IDLE; buffer pointers, retry counter and timeout counter = 0.
- IDLE: request accepted when req_valid & req_ready. Latch addr, write and len; req_ready drops next cycle.
  - Read: go to ARB.
  - Write: go to LOAD.
- LOAD: accept one wdata word per wdata_valid into the buffer, indexes 0..len. After len+1 words, go to ARB. wdata_valid outside LOAD is ignored.
- ARB: rqst=1 and arbcy=1. Move to ADDR on the first cycle with arb_grant & ~bus_busy.
- ADDR (exactly 1 cycle): start=1, ad_oe=1, tm_oe=1, rqst drops.
  - Block transfers: ad_o = {addr[31:6], block code in [5:2], 2'b00}; code = log2(len+1) per NuBus block encoding.
  - Single transfers: ad_o = addr.
  - tm_o = {~write, 1}, full-word mode.
- DATA:
  - Write: ad_oe=1, ad_o = buffer[beat]; beat advances on each intermediate beat.
  - Read: ad_oe=0; on an intermediate beat or final ack, rdata=ad_i and rdata_valid=1 for 1 cycle.
  - ack_i ends the phase; go to CHECK with tm_i latched.
  - Beat index saturates at len. An extra intermediate beat is ignored; it does not overflow.
- CHECK (1 cycle), by latched tm_i:
  - 00: done, status 0.
  - 01 or 10: done, status 1.
  - 11: if retry count < RETRY_MAX, go to GAP; else done, status 3.
  - On retry, read data already emitted is not retracted. The whole block is re-issued and the CPU discards earlier words on retry.
- GAP: wait RETRY_GAP cycles, then go to ARB; retry counter +1. Write buffer contents are preserved.
- done strobes 1 cycle, then IDLE; req_ready=1 the following cycle. Retry counter clears on return to IDLE.
- ack_i in the ADDR cycle is treated as a single-beat final ack.
- Reset mid-transfer: all drives (start, rqst, ad_oe, tm_oe) deassert asynchronously; no done pulse.

Optional Feature:
- NUBUS_BURST_TIMEOUT_EN defined: an 8..16-bit counter increments each DATA cycle with no beat or ack, and clears on any beat. On reaching TIMEOUT_CYCLES: drop ad_oe, done with status 2, go to IDLE.
- Undefined: no counter; DATA waits indefinitely and status 2 is never produced.

Test Plan:
- Single read, addr 0xF9000010, grant at cycle 2, ack_i with tm_i=00 two cycles after ADDR, ad_i=0xDEADBEEF -> ad_o=0xF9000010 during start; rdata=0xDEADBEEF with rdata_valid; done, status 0.
- Block write len=3, push 0x1..0x4 -> ADDR ad_o[5:2]=block code for 4 words; ad_o sequence 1,2,3,4 across three intermediate beats plus final ack; status 0.
- Block read len=7 -> exactly 8 rdata_valid pulses matching the ad_i sequence; done on the final ack.
- tm_i=11 on every ack, RETRY_MAX=2 -> three START pulses, each separated by ≥RETRY_GAP+1 cycles; done, status 3.
- NUBUS_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> done with status 2 exactly 16 DATA cycles after ADDR, ad_oe=0. Without the macro -> FSM remains in DATA.
- Assert nub_reset during DATA of a block write -> start, rqst and ad_oe are 0 immediately; after release req_ready=1 and no done pulse.
